// File: rtl/mips_pkg.sv
// Shared MIPS definitions: R-type opcode/funct codes used by the decoder and
// hazard unit, plus the state encoding of the multi-cycle DIVU/HI/LO unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'd0;
  localparam logic [5:0] FUNCT_DIVU = 6'd27;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage : mips_pkg

// File: rtl/divu_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, retire one quotient bit.
// Ports:
//   r_i / q_i / d_i : partial remainder, quotient shift register, divisor
//   r_o / q_o       : updated remainder and quotient shift register
module divu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  // Shifted remainder kept one bit wider so the compare never overflows.
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] d_ext;
  logic           fits;

  assign r_shift = {r_i, q_i[WIDTH-1]};
  assign d_ext   = {1'b0, d_i};
  assign fits    = (r_shift >= d_ext);

  // After a successful subtract the result is below the divisor, so it fits in WIDTH bits.
  always_comb begin
    r_o = WIDTH'(r_shift);
    if (fits) begin
      r_o = WIDTH'(r_shift - d_ext);
    end
    q_o = {q_i[WIDTH-2:0], fits};
  end

endmodule : divu_step

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider with the architectural HI/LO pair.
// A DIVU in EX starts a WIDTH-cycle restoring divide; HI gets the remainder
// and LO the quotient on the final step. MFHI/MFLO in ID/EX are stalled while busy.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : DIVU valid in EX, accepted in IDLE or DONE
//   dividend, divisor   : operands captured on the accept edge
//   mf_req              : MFHI/MFLO present in ID/EX
//   busy, done          : divide running / one-cycle HI/LO-updated pulse
//   stall_req           : combinational mf_req & busy
//   hi, lo              : HI (remainder) and LO (quotient) registers
module divu_hilo_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // Single iteration datapath, reused once per RUN cycle.
  divu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_i(rem_q),
    .q_i(quo_q),
    .d_i(dsr_q),
    .r_o(rem_step),
    .q_o(quo_step)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic; a start in DONE relaunches immediately so divides chain without a bubble.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = rem_step;
          lo_d    = quo_step;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Starts while RUN are ignored; operands are never re-captured mid-divide.
    if (start && (state_q != RUN)) begin
      dsr_d   = divisor;
      quo_d   = dividend;
      rem_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign stall_req = mf_req & busy;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule : divu_hilo_unit
